// File: rtl/pong_ball_sequencer.sv
// Per-frame ball/score sequencer: serve, play, point-pause and game-over phases.
// Optional AUTO_SERVE_EN: serve automatically after SERVE_FRAMES idle frames.
//   state  | meaning
//   SERVE  | ball centred, waiting for a serve
//   PLAY   | ball moving, collisions evaluated each frame
//   POINT  | ball frozen for PAUSE_FRAMES after a score
//   OVER   | a player reached WIN_SCORE, waiting for serveButton
module pong_ball_sequencer #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_W       = 16,
  parameter int BALL_H       = 16,
  parameter int INIT_X_SPEED = 4,
  parameter int INIT_Y_SPEED = 2,
  parameter int MAX_X_SPEED  = 12,
  parameter int PAUSE_FRAMES = 30,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic        pixelClock,
  input  logic        reset,
  input  logic        vSyncStart,
  input  logic        collisionBallScreenLeft,
  input  logic        collisionBallScreenRight,
  input  logic        collisionBallScreenTop,
  input  logic        collisionBallScreenBottom,
  input  logic        collisionBallPlayerPaddle,
  input  logic        collisionBallComputerPaddle,
  input  logic        serveButton,
  output logic [15:0] ballX,
  output logic [15:0] ballY,
  output logic [7:0]  ballXSpeed,
  output logic [7:0]  ballYSpeed,
  output logic [3:0]  playerScore,
  output logic [3:0]  computerScore,
  output logic [1:0]  gameState,
  output logic        gameOver
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

`ifdef AUTO_SERVE_EN
  localparam bit AUTO_SERVE = 1'b1;
`else
  localparam bit AUTO_SERVE = 1'b0;
`endif

  localparam logic [15:0] X_CENTRE  = 16'((SCREEN_W - BALL_W) / 2);
  localparam logic [15:0] Y_CENTRE  = 16'((SCREEN_H - BALL_H) / 2);
  localparam logic [16:0] X_MAX     = 17'(SCREEN_W - BALL_W);
  localparam logic [16:0] Y_MAX     = 17'(SCREEN_H - BALL_H);
  localparam logic [15:0] X_MAX16   = 16'(SCREEN_W - BALL_W);
  localparam logic [15:0] Y_MAX16   = 16'(SCREEN_H - BALL_H);
  localparam logic [7:0]  INIT_XS   = 8'(INIT_X_SPEED);
  localparam logic [7:0]  INIT_YS   = 8'(INIT_Y_SPEED);
  localparam logic [7:0]  MAX_XS    = 8'(MAX_X_SPEED);
  localparam logic [6:0]  PAUSE_CNT = 7'(PAUSE_FRAMES);
  localparam logic [6:0]  SERVE_CNT = 7'(SERVE_FRAMES);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  state_t      r_state;
  logic [15:0] r_ball_x;
  logic [15:0] r_ball_y;
  logic [7:0]  r_x_speed;
  logic [7:0]  r_y_speed;
  logic [3:0]  r_player_score;
  logic [3:0]  r_computer_score;
  logic        r_x_dir_right;
  logic        r_y_dir_down;
  logic        r_serve_right;
  logic        r_serve_req;
  logic        r_eval;
  logic        r_move;
  logic [6:0]  r_frame_cnt;

  logic [16:0] w_x_ext, w_xs_ext, w_x_sum;
  logic [16:0] w_y_ext, w_ys_ext, w_y_sum;
  logic [15:0] w_x_next, w_y_next;
  logic [7:0]  w_xs_inc;
  logic [3:0]  w_ps_inc, w_cs_inc;
  logic [6:0]  w_cnt_inc;
  logic        w_auto_fire;

  // 17-bit intermediates so neither the add nor the subtract can wrap.
  assign w_x_ext  = {1'b0, r_ball_x};
  assign w_xs_ext = {9'd0, r_x_speed};
  assign w_x_sum  = w_x_ext + w_xs_ext;
  assign w_y_ext  = {1'b0, r_ball_y};
  assign w_ys_ext = {9'd0, r_y_speed};
  assign w_y_sum  = w_y_ext + w_ys_ext;

  assign w_x_next = r_x_dir_right ? ((w_x_sum > X_MAX) ? X_MAX16 : w_x_sum[15:0])
                                  : ((w_x_ext < w_xs_ext) ? 16'd0 : r_ball_x - {8'd0, r_x_speed});
  assign w_y_next = r_y_dir_down  ? ((w_y_sum > Y_MAX) ? Y_MAX16 : w_y_sum[15:0])
                                  : ((w_y_ext < w_ys_ext) ? 16'd0 : r_ball_y - {8'd0, r_y_speed});

  assign w_xs_inc    = (r_x_speed >= MAX_XS) ? MAX_XS : r_x_speed + 8'd1;
  assign w_ps_inc    = r_player_score + 4'd1;
  assign w_cs_inc    = r_computer_score + 4'd1;
  assign w_cnt_inc   = r_frame_cnt + 7'd1;
  assign w_auto_fire = AUTO_SERVE && (w_cnt_inc == SERVE_CNT);

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_state          <= ST_SERVE;
      r_ball_x         <= X_CENTRE;
      r_ball_y         <= Y_CENTRE;
      r_x_speed        <= INIT_XS;
      r_y_speed        <= INIT_YS;
      r_player_score   <= 4'd0;
      r_computer_score <= 4'd0;
      r_x_dir_right    <= 1'b0;
      r_y_dir_down     <= 1'b1;
      r_serve_right    <= 1'b0;
      r_serve_req      <= 1'b0;
      r_eval           <= 1'b0;
      r_move           <= 1'b0;
      r_frame_cnt      <= 7'd0;
    end else begin
      r_eval <= vSyncStart && !r_eval && !r_move;
      r_move <= r_eval;

      if (r_state == ST_SERVE && serveButton)
        r_serve_req <= 1'b1;

      if (r_eval) begin
        case (r_state)
          ST_SERVE: begin
            if (r_serve_req || serveButton || w_auto_fire) begin
              r_x_dir_right <= r_serve_right;
              r_x_speed     <= INIT_XS;
              r_serve_req   <= 1'b0;
              r_frame_cnt   <= 7'd0;
              r_state       <= ST_PLAY;
            end else if (AUTO_SERVE) begin
              r_frame_cnt <= w_cnt_inc;
            end
          end
          ST_PLAY: begin
            // A paddle only counts when the ball is heading toward it.
            if (collisionBallPlayerPaddle && !r_x_dir_right) begin
              r_x_dir_right <= 1'b1;
              r_x_speed     <= w_xs_inc;
            end else if (collisionBallComputerPaddle && r_x_dir_right) begin
              r_x_dir_right <= 1'b0;
              r_x_speed     <= w_xs_inc;
            end else if (collisionBallScreenLeft) begin
              r_computer_score <= w_cs_inc;
              r_serve_right    <= 1'b0;
              r_state          <= (w_cs_inc == WIN) ? ST_OVER : ST_POINT;
            end else if (collisionBallScreenRight) begin
              r_player_score <= w_ps_inc;
              r_serve_right  <= 1'b1;
              r_state        <= (w_ps_inc == WIN) ? ST_OVER : ST_POINT;
            end
            if (collisionBallScreenTop)
              r_y_dir_down <= 1'b1;
            if (collisionBallScreenBottom)
              r_y_dir_down <= 1'b0;
          end
          ST_POINT: begin
            if (w_cnt_inc == PAUSE_CNT) begin
              r_ball_x    <= X_CENTRE;
              r_ball_y    <= Y_CENTRE;
              r_x_speed   <= INIT_XS;
              r_frame_cnt <= 7'd0;
              r_state     <= ST_SERVE;
            end else begin
              r_frame_cnt <= w_cnt_inc;
            end
          end
          default: ;
        endcase
      end

      if (r_state == ST_OVER && serveButton) begin
        r_player_score   <= 4'd0;
        r_computer_score <= 4'd0;
        r_ball_x         <= X_CENTRE;
        r_ball_y         <= Y_CENTRE;
        r_serve_right    <= 1'b0;
        r_serve_req      <= 1'b0;
        r_frame_cnt      <= 7'd0;
        r_state          <= ST_SERVE;
      end

      if (r_move && r_state == ST_PLAY) begin
        r_ball_x <= w_x_next;
        r_ball_y <= w_y_next;
      end
    end
  end

  assign ballX         = r_ball_x;
  assign ballY         = r_ball_y;
  assign ballXSpeed    = r_x_speed;
  assign ballYSpeed    = r_y_speed;
  assign playerScore   = r_player_score;
  assign computerScore = r_computer_score;
  assign gameState     = r_state;
  assign gameOver      = (r_state == ST_OVER);

endmodule
